gate_sweep_checker: RTL and testbench



---
 rtl/gate_sweep_checker_pkg.sv | 24 ++
 rtl/gate_sweep_checker_sync2.sv | 30 +++
 rtl/gate_sweep_checker.sv | 180 ++++++++++++++++++
 tb/tb_gate_sweep_checker.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_checker_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gate_chk_pkg                                                               |
// | FSM state encoding and stock truth tables ({A,B} indexed) for the checker. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package gate_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage
`default_nettype wire

// File: rtl/gate_sweep_checker_sync2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync2                                                                      |
// | Two-flop synchroniser, asynchronous active-high reset to 0.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule
`default_nettype wire

// File: rtl/gate_sweep_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gate_sweep_checker                                                         |
// | Sweeps a 2-input gate through 00,01,10,11 and checks Z against EXPECTED.   |
// | Optional first-failure capture: define GATE_SWEEP_FAIL_CAPTURE_EN.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gate_sweep_checker
    import gate_chk_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 4,
    parameter logic [3:0] EXPECTED      = TT_NAND,
    parameter int         PASSES        = 1,
    parameter int         ERR_W         = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             Z_IN,
    output logic             A_OUT,
    output logic             B_OUT,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
    ,
    output logic             FAIL_VALID,
    output logic [1:0]       FAIL_IDX
`endif
);

    // SETTLE_CYCLES >= 3, so the width is always at least 2 and holds SETTLE_CYCLES-1
    localparam int c_SET_W  = $clog2(SETTLE_CYCLES);
    localparam int c_PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

    localparam logic [c_SET_W-1:0]  c_SET_LOAD  = c_SET_W'(SETTLE_CYCLES - 1);
    localparam logic [c_PASS_W-1:0] c_PASS_LAST = c_PASS_W'(PASSES - 1);
    localparam logic [ERR_W-1:0]    c_ERR_MAX   = '1;

    state_t              state_q,    state_d;
    logic [1:0]          idx_q,      idx_d;
    logic [c_PASS_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [c_SET_W-1:0]  settle_q,   settle_d;
    logic [ERR_W-1:0]    err_q,      err_d;
    logic                a_q,        a_d;
    logic                b_q,        b_d;
    logic                pass_q,     pass_d;
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
    logic                fail_valid_q, fail_valid_d;
    logic [1:0]          fail_idx_q,   fail_idx_d;
`endif

    logic z_sync;
    logic mismatch;

    sync2 u_sync_z (
        .clk (CLK),
        .rst (RST),
        .i_d (Z_IN),
        .o_q (z_sync)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pass_cnt_d = pass_cnt_q;
        settle_d   = settle_q;
        err_d      = err_q;
        a_d        = a_q;
        b_d        = b_q;
        pass_d     = pass_q;
        mismatch   = 1'b0;
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
        fail_valid_d = fail_valid_q;
        fail_idx_d   = fail_idx_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_d    = ST_DRIVE;
                    idx_d      = 2'd0;
                    pass_cnt_d = '0;
                    err_d      = '0;
                    pass_d     = 1'b0;
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
                    fail_valid_d = 1'b0;
                    fail_idx_d   = 2'd0;
`endif
                end
            end
            ST_DRIVE: begin
                a_d      = idx_q[1];
                b_d      = idx_q[0];
                settle_d = c_SET_LOAD;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    settle_d = settle_q - c_SET_W'(1);
                end
            end
            ST_SAMPLE: begin
                mismatch = (z_sync != EXPECTED[idx_q]);
                if (mismatch && (err_q != c_ERR_MAX)) begin
                    err_d = err_q + ERR_W'(1);
                end
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
                if (mismatch && !fail_valid_q) begin
                    fail_valid_d = 1'b1;
                    fail_idx_d   = idx_q;
                end
`endif
                if (idx_q != 2'd3) begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_DRIVE;
                end else if (pass_cnt_q < c_PASS_LAST) begin
                    idx_d      = 2'd0;
                    pass_cnt_d = pass_cnt_q + c_PASS_W'(1);
                    state_d    = ST_DRIVE;
                end else begin
                    // verdict includes the compare made in this very cycle
                    pass_d  = (err_d == '0);
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            idx_q      <= 2'd0;
            pass_cnt_q <= '0;
            settle_q   <= '0;
            err_q      <= '0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pass_cnt_q <= pass_cnt_d;
            settle_q   <= settle_d;
            err_q      <= err_d;
            a_q        <= a_d;
            b_q        <= b_d;
            pass_q     <= pass_d;
        end
    end

`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fail_valid_q <= 1'b0;
            fail_idx_q   <= 2'd0;
        end else begin
            fail_valid_q <= fail_valid_d;
            fail_idx_q   <= fail_idx_d;
        end
    end

    assign FAIL_VALID = fail_valid_q;
    assign FAIL_IDX   = fail_idx_q;
`endif

    assign A_OUT   = a_q;
    assign B_OUT   = b_q;
    assign BUSY    = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign DONE    = (state_q == ST_DONE);
    assign PASS    = pass_q;
    assign ERR_CNT = err_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gate_sweep_checker                                                      |
// | Scoreboard bench: random gate tables vs. an arithmetic sweep model.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_gate_sweep_checker;
    import gate_chk_pkg::*;

    localparam int c_S1  = 4;
    localparam int c_P1  = 1;
    localparam int c_EW1 = 4;
    localparam int c_T1  = 4 * c_P1 * (c_S1 + 2);
    localparam int c_S3  = 4;
    localparam int c_P3  = 3;
    localparam int c_EW3 = 2;
    localparam int c_T3  = 4 * c_P3 * (c_S3 + 2);

    typedef struct {
        int         done_edge;
        int         err;
        logic       pass;
        logic       fvalid;
        logic [1:0] fidx;
    } exp_t;

    logic             clk     = 1'b0;
    logic             rst     = 1'b0;
    logic             rst3    = 1'b0;
    logic             start   = 1'b0;
    logic             start3  = 1'b0;
    logic [3:0]       gut_tt  = TT_NAND;
    logic [3:0]       gut_tt3 = 4'b0000;
    wire              z1;
    wire              z3;
    logic             a1, b1, busy1, done1, pass1;
    logic [c_EW1-1:0] err1;
    logic             a3, b3, busy3, done3, pass3;
    logic [c_EW3-1:0] err3;
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
    logic             fv1, fv3;
    logic [1:0]       fi1, fi3;
`endif

    int         edge_n        = 0;
    int         checks        = 0;
    int         failures      = 0;
    exp_t       q1[$];
    exp_t       q3[$];
    int         acc1          = -1;
    int         done1_e       = 0;
    logic [1:0] ab_before1    = 2'b00;
    int         acc3          = -1;
    int         done3_e       = 0;
    bit         dut3_finished = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    // behavioural gate under test: table lookup with a propagation delay
    assign #3 z1 = gut_tt[{a1, b1}];
    assign #3 z3 = gut_tt3[{a3, b3}];

    gate_sweep_checker #(
        .SETTLE_CYCLES (c_S1),
        .EXPECTED      (TT_NAND),
        .PASSES        (c_P1),
        .ERR_W         (c_EW1)
    ) u_dut (
        .CLK     (clk),
        .RST     (rst),
        .START   (start),
        .Z_IN    (z1),
        .A_OUT   (a1),
        .B_OUT   (b1),
        .BUSY    (busy1),
        .DONE    (done1),
        .PASS    (pass1),
        .ERR_CNT (err1)
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
        ,
        .FAIL_VALID (fv1),
        .FAIL_IDX   (fi1)
`endif
    );

    gate_sweep_checker #(
        .SETTLE_CYCLES (c_S3),
        .EXPECTED      (TT_NAND),
        .PASSES        (c_P3),
        .ERR_W         (c_EW3)
    ) u_dut3 (
        .CLK     (clk),
        .RST     (rst3),
        .START   (start3),
        .Z_IN    (z3),
        .A_OUT   (a3),
        .B_OUT   (b3),
        .BUSY    (busy3),
        .DONE    (done3),
        .PASS    (pass3),
        .ERR_CNT (err3)
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
        ,
        .FAIL_VALID (fv3),
        .FAIL_IDX   (fi3)
`endif
    );

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, actual, expected, edge_n);
        end
    endtask

    // Sweep outcome from the gate table alone: every differing table entry is
    // one mismatch per pass, counted in vector order, clipped at the counter max.
    function automatic exp_t predict(input logic [3:0] tt, input int passes,
                                     input int err_max, input int done_edge);
        exp_t       r;
        logic [3:0] want;
        int         mism;
        want        = TT_NAND;
        mism        = 0;
        r.done_edge = done_edge;
        r.fvalid    = 1'b0;
        r.fidx      = 2'b00;
        for (int k = 0; k < 4; k++) begin
            if (tt[k] != want[k]) begin
                if (!r.fvalid) begin
                    r.fvalid = 1'b1;
                    r.fidx   = 2'(k);
                end
                mism++;
            end
        end
        r.err  = (mism * passes > err_max) ? err_max : mism * passes;
        r.pass = (r.err == 0);
        return r;
    endfunction

    // Vector k of a sweep is presented on the edge 1 + k*(SETTLE+2) after acceptance.
    function automatic int exp_ab1();
        int t;
        if (acc1 < 0) return 0;
        t = edge_n - acc1;
        if (t < 1) return int'(ab_before1);
        if (t >= c_T1) return 3;
        return ((t - 1) / (c_S1 + 2)) % 4;
    endfunction

    // Called just after a falling edge; the model decides acceptance for the next rising edge.
    task automatic drive_start(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            start = 1'b1;
            if (acc1 < 0 || edge_n + 1 > done1_e) begin
                ab_before1 = (acc1 < 0) ? 2'b00 : 2'b11;
                acc1       = edge_n + 1;
                done1_e    = acc1 + c_T1;
                q1.push_back(predict(gut_tt, c_P1, (1 << c_EW1) - 1, done1_e));
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic wait_idle1();
        int n = 0;
        while ((q1.size() != 0 || (acc1 >= 0 && edge_n < done1_e)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("idle_timeout", 0, 1);
            q1.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check("rst_levels", int'({a1, b1, busy1, done1, pass1}), 0);
        check("rst_err_cnt", int'(err1), 0);
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
        check("rst_fail_capture", int'({fv1, fi1}), 0);
`endif
        acc1 = -1;
        q1.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : mon1
        logic done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            check("ab", int'({a1, b1}), exp_ab1());
            check("busy", int'(busy1), (acc1 >= 0 && edge_n >= acc1 && edge_n < done1_e) ? 1 : 0);
            check("done", int'(done1), (acc1 >= 0 && edge_n >= done1_e) ? 1 : 0);
            if (done1 && !done_prev) begin
                if (q1.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    e = q1.pop_front();
                    check("done_edge", edge_n, e.done_edge);
                    check("err_cnt", int'(err1), e.err);
                    check("pass", int'(pass1), int'(e.pass));
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
                    check("fail_valid", int'(fv1), int'(e.fvalid));
                    check("fail_idx", int'(fi1), int'(e.fidx));
`endif
                end
            end
            done_prev = done1;
        end
    end

    initial begin : mon3
        logic done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            check("busy3", int'(busy3), (acc3 >= 0 && edge_n >= acc3 && edge_n < done3_e) ? 1 : 0);
            if (done3 && !done_prev) begin
                if (q3.size() == 0) begin
                    check("done3_unexpected", 1, 0);
                end else begin
                    e = q3.pop_front();
                    check("done3_edge", edge_n, e.done_edge);
                    check("err_cnt3", int'(err3), e.err);
                    check("pass3", int'(pass3), int'(e.pass));
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
                    check("fail_valid3", int'(fv3), int'(e.fvalid));
                    check("fail_idx3", int'(fi3), int'(e.fidx));
`endif
                end
            end
            done_prev = done3;
        end
    end

    // Three-pass, 2-bit-counter instance: first sweep has Z stuck at 0 (9 raw mismatches).
    initial begin : stim3
        #2 rst3 = 1'b1;
        repeat (2) @(negedge clk);
        rst3 = 1'b0;
        for (int n = 0; n < 4; n++) begin
            gut_tt3 = (n == 0) ? 4'b0000 : 4'($urandom);
            @(negedge clk);
            start3  = 1'b1;
            acc3    = edge_n + 1;
            done3_e = acc3 + c_T3;
            q3.push_back(predict(gut_tt3, c_P3, (1 << c_EW3) - 1, done3_e));
            @(negedge clk);
            start3 = 1'b0;
            repeat (c_T3 + $urandom_range(1, 5)) @(negedge clk);
        end
        dut3_finished = 1'b1;
    end

    initial begin : stim
        int gap;
        int n;
        #2 rst = 1'b1;
        #1;
        check("reset_levels", int'({a1, b1, busy1, done1, pass1}), 0);
        check("reset_err_cnt", int'(err1), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        gut_tt = TT_NAND;
        drive_start(1);
        wait_idle1();
        gut_tt = TT_NOR;
        drive_start(1);
        wait_idle1();
        gut_tt = 4'b1111;
        drive_start(1);
        wait_idle1();

        // reset lands in the settle window of vector 2, after one mismatch is counted
        gut_tt = TT_NOR;
        drive_start(1);
        repeat (2 * (c_S1 + 2) + 2) @(negedge clk);
        pulse_reset();
        repeat (3) @(negedge clk);
        gut_tt = TT_NAND;
        drive_start(1);
        wait_idle1();

        gut_tt = TT_XOR;
        drive_start(1);
        repeat (3) @(negedge clk);
        drive_start(1);
        wait_idle1();

        gut_tt = TT_OR;
        drive_start(3 * c_T1 + 4);
        wait_idle1();

        for (int k = 0; k < 25; k++) begin
            if (acc1 < 0 || edge_n + 1 > done1_e) gut_tt = 4'($urandom);
            gap = $urandom_range(0, 30);
            repeat (gap) @(negedge clk);
            drive_start($urandom_range(1, 3));
        end
        wait_idle1();

        n = 0;
        while (!dut3_finished && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!dut3_finished) check("dut3_timeout", 0, 1);
        check("q1_drained", q1.size(), 0);
        check("q3_drained", q3.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
